// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared widths, timeout length and FSM states for apb_req_arbiter
package apb_arb_pkg;
  localparam int ADDR_W      = 9;
  localparam int DATA_W      = 8;
  localparam int NUM_REQ     = 2;
  localparam int TIMEOUT_CYC = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_e;
endpackage

// File: rtl/apb_rr_pick.sv
// apb_rr_pick: two-way round-robin selector favouring the requester not served last
module apb_rr_pick
  import apb_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_served,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_idx
);
  always_comb begin
    grant_idx = (&req) ? ~last_served : req[1];
    grant     = {grant_idx, ~grant_idx} & {NUM_REQ{|req}};
  end
endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: two-requester round-robin front end driving a two-slave APB bus.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC cycles without pready.
module apb_req_arbiter
  import apb_arb_pkg::*;
(
  input  logic                           pclk,
  input  logic                           presetn,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             read_write,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]             done,
  output logic [NUM_REQ-1:0]             err,
  output logic [DATA_W-1:0]              rdata,
  output logic                           grant_id,
  output logic                           psel1,
  output logic                           psel2,
  output logic                           penable,
  output logic                           pwrite,
  output logic [ADDR_W-2:0]              paddr,
  output logic [DATA_W-1:0]              pwdata,
  input  logic [DATA_W-1:0]              prdata,
  input  logic                           pready,
  input  logic                           pslverr
);
  state_e             state_q, state_d;
  logic               owner_q, owner_d, last_q, last_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic [NUM_REQ-1:0] done_q, done_d, err_q, err_d, pick;
  logic               pick_idx, grant, tmo, fin, fail, busy;

  apb_rr_pick u_pick (
    .req         (req),
    .last_served (last_q),
    .grant       (pick),
    .grant_idx   (pick_idx)
  );

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    tmo   = state_q == ACCESS && !pready && cnt_q == CNT_W'(TIMEOUT_CYC - 1);
    cnt_d = state_q == ACCESS ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  // a timeout completes with pready low, so it reports as an error with zero data
  always_comb begin
    grant    = state_q == IDLE && |pick && ~|done_q;
    fin      = state_q == ACCESS && (pready || tmo);
    fail     = pslverr || !pready;
    busy     = state_q != IDLE;
    state_d  = grant ? SETUP : state_q == SETUP ? ACCESS : fin ? IDLE : state_q;
    owner_d  = grant ? pick_idx : owner_q;
    last_d   = grant ? pick_idx : last_q;
    pwrite_d = grant ? read_write[pick_idx] : pwrite_q;
    addr_d   = grant ? addr[pick_idx] : addr_q;
    pwdata_d = grant ? wdata[pick_idx] : pwdata_q;
    done_d   = {owner_q, ~owner_q} & {NUM_REQ{fin}};
    err_d    = done_d & {NUM_REQ{fail}};
    rdata_d  = !fin ? rdata_q : fail ? '0 : pwrite_q ? rdata_q : prdata;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      pwrite_q <= 1'b0;
      addr_q   <= '0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      pwrite_q <= pwrite_d;
      addr_q   <= addr_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign psel1    = busy && !addr_q[ADDR_W-1];
  assign psel2    = busy && addr_q[ADDR_W-1];
  assign penable  = state_q == ACCESS;
  assign pwrite   = pwrite_q;
  assign paddr    = addr_q[ADDR_W-2:0];
  assign pwdata   = pwdata_q;
  assign rdata    = rdata_q;
  assign done     = done_q;
  assign err      = err_q;
  assign grant_id = owner_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: scoreboard bench with a transaction-level arbiter/slave model
module tb_apb_req_arbiter;
  logic pclk = 1'b0, presetn;
  logic [1:0] req, read_write, done, err;
  logic [1:0][8:0] addr;
  logic [1:0][7:0] wdata;
  logic [7:0] rdata, paddr, pwdata, prdata;
  logic grant_id, psel1, psel2, penable, pwrite, pready, pslverr;
`ifdef APB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  typedef struct { int id; logic [7:0] rdata; logic err; } sb_t;
  typedef struct { int id; logic [7:0] paddr; logic [7:0] pwdata; logic pwrite; logic sel2; } apb_t;
  typedef struct { int waits; logic [7:0] prdata; logic err; } slv_t;
  sb_t  sbq[$];
  apb_t apbq[$];
  slv_t slvq[$];
  apb_t cur;
  slv_t r_slv[2];
  logic [1:0] r_rw;
  logic [8:0] r_addr[2];
  logic [7:0] r_wd[2];
  logic [7:0] exp_rd;
  int last_srv, lat[2];
  int n_pass = 0, n_tot = 0;

  apb_req_arbiter dut (
    .pclk(pclk), .presetn(presetn), .req(req), .read_write(read_write), .addr(addr),
    .wdata(wdata), .done(done), .err(err), .rdata(rdata), .grant_id(grant_id),
    .psel1(psel1), .psel2(psel2), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endfunction

  // service order follows the round-robin rule; expectations queued in that order
  task automatic issue(input logic [1:0] m, input bit scr);
    int ord[$];
    int id, cyc;
    logic [1:0] pend;
    bit to;
    cyc = 0;
    pend = m;
    if (m == 2'b11) begin
      ord.push_back(1 - last_srv);
      ord.push_back(last_srv);
    end else begin
      ord.push_back(m[1] ? 1 : 0);
      last_srv = ord[0];
    end
    foreach (ord[k]) begin
      id = ord[k];
      to = TO_EN && r_slv[id].waits >= 16;
      apbq.push_back('{id, r_addr[id][7:0], r_wd[id], r_rw[id], r_addr[id][8]});
      slvq.push_back(r_slv[id]);
      if (r_slv[id].err || to) exp_rd = 8'h00;
      else if (!r_rw[id]) exp_rd = r_slv[id].prdata;
      sbq.push_back('{id, exp_rd, r_slv[id].err || to});
    end
    @(posedge pclk); #1;
    for (int i = 0; i < 2; i++)
      if (m[i]) begin
        read_write[i] = r_rw[i];
        addr[i] = r_addr[i];
        wdata[i] = r_wd[i];
      end
    req = m;
    while (pend != 2'b00 && cyc < 100) begin
      @(negedge pclk);
      cyc++;
      for (int i = 0; i < 2; i++)
        if (pend[i] && done[i]) begin
          req[i] = 1'b0;
          pend[i] = 1'b0;
          lat[i] = cyc - 1;
        end
      if (scr && cyc >= 2 && pend[ord[0]]) begin
        addr[ord[0]] = 9'($urandom);
        wdata[ord[0]] = 8'($urandom);
        read_write[ord[0]] = 1'($urandom);
      end
    end
    chk("all_done", 32'(pend), 0);
  endtask

  initial begin : sb_mon
    sb_t e;
    logic [1:0] oh;
    forever begin
      @(negedge pclk);
      if (done !== 2'b00) begin
        if (sbq.size() == 0) chk("unexpected_done", 32'(done), 0);
        else begin
          e = sbq.pop_front();
          oh = 2'b01 << e.id;
          chk("done_owner", 32'(done), 32'(oh));
          chk("err", 32'(err), e.err ? 32'(oh) : 0);
          chk("rdata", 32'(rdata), 32'(e.rdata));
          chk("bus_idle_at_done", 32'({psel1, psel2, penable}), 0);
        end
      end
    end
  end

  initial begin : apb_mon
    forever begin
      @(negedge pclk);
      if (psel1 || psel2) begin
        chk("psel_exclusive", 32'(psel1 & psel2), 0);
        if (!penable) begin
          if (apbq.size() == 0) chk("unexpected_setup", 32'({psel1, psel2}), 0);
          else begin
            cur = apbq.pop_front();
            chk("grant_id", 32'(grant_id), cur.id);
            chk("psel_sel", 32'({psel1, psel2}), cur.sel2 ? 1 : 2);
            chk("paddr", 32'(paddr), 32'(cur.paddr));
            chk("pwdata", 32'(pwdata), 32'(cur.pwdata));
            chk("pwrite", 32'(pwrite), 32'(cur.pwrite));
          end
        end else begin
          chk("paddr_hold", 32'(paddr), 32'(cur.paddr));
          chk("pwdata_hold", 32'(pwdata), 32'(cur.pwdata));
          chk("pwrite_hold", 32'(pwrite), 32'(cur.pwrite));
        end
      end
    end
  end

  initial begin : slave
    slv_t r;
    int wt;
    wt = 0;
    r = '{0, 8'h00, 1'b0};
    pready = 1'b0;
    prdata = 8'h00;
    pslverr = 1'b0;
    forever begin
      @(negedge pclk);
      if ((psel1 || psel2) && !penable && slvq.size() > 0) begin
        r = slvq.pop_front();
        wt = r.waits;
        pready = 1'b0;
      end else if (psel1 || psel2) begin
        pready = wt == 0;
        prdata = pready ? r.prdata : 8'($urandom);
        pslverr = pready ? r.err : 1'($urandom);
        if (wt > 0) wt--;
      end else pready = 1'b0;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int cyc;
    presetn = 1'b1;
    req = '0;
    read_write = '0;
    addr = '0;
    wdata = '0;
    last_srv = 1;
    exp_rd = 8'h00;
    #1 presetn = 1'b0;
    #2;
    chk("rst_psel", 32'({psel1, psel2, penable}), 0);
    chk("rst_bus", 32'({pwrite, paddr, pwdata}), 0);
    chk("rst_resp", 32'({rdata, done, err, grant_id}), 0);
    @(posedge pclk); #1 presetn = 1'b1;
    r_rw = 2'b01;
    r_addr[0] = 9'h012; r_wd[0] = 8'h11; r_slv[0] = '{0, 8'h00, 1'b0};
    r_addr[1] = 9'h134; r_wd[1] = 8'h22; r_slv[1] = '{1, 8'h5A, 1'b0};
    issue(2'b11, 1'b0);
    r_rw[0] = 1'b1; r_addr[0] = 9'h005; r_wd[0] = 8'hA5; r_slv[0] = '{0, 8'hEE, 1'b0};
    issue(2'b01, 1'b0);
    chk("lat_req0", lat[0], 3);
    r_rw[1] = 1'b0; r_addr[1] = 9'h10A; r_wd[1] = 8'h99; r_slv[1] = '{0, 8'h3C, 1'b0};
    issue(2'b10, 1'b0);
    chk("lat_req1", lat[1], 3);
    r_rw[0] = 1'b0; r_addr[0] = 9'h040; r_wd[0] = 8'h00; r_slv[0] = '{2, 8'hFF, 1'b1};
    issue(2'b01, 1'b1);
    r_rw[0] = 1'b0; r_addr[0] = 9'h1C3; r_wd[0] = 8'h01; r_slv[0] = '{20, 8'h77, 1'b0};
    issue(2'b01, 1'b0);
    chk("wait20_lat", lat[0], TO_EN ? 18 : 23);
    r_rw[1] = 1'b0; r_addr[1] = 9'h155; r_wd[1] = 8'h33; r_slv[1] = '{8, 8'h44, 1'b0};
    apbq.push_back('{1, 8'h55, 8'h33, 1'b0, 1'b1});
    slvq.push_back(r_slv[1]);
    @(posedge pclk); #1;
    read_write[1] = 1'b0; addr[1] = 9'h155; wdata[1] = 8'h33; req = 2'b10;
    cyc = 0;
    while (!penable && cyc < 20) begin
      @(negedge pclk);
      cyc++;
    end
    chk("reached_access", 32'(penable), 1);
    #2 presetn = 1'b0;
    #1;
    chk("rst_abort_psel", 32'({psel1, psel2, penable}), 0);
    chk("rst_abort_resp", 32'({rdata, done, err, grant_id}), 0);
    req = 2'b00;
    last_srv = 1;
    exp_rd = 8'h00;
    repeat (2) @(posedge pclk);
    #1 presetn = 1'b1;
    repeat (3) @(negedge pclk);
    r_rw = 2'b10;
    r_addr[0] = 9'h0F0; r_wd[0] = 8'h5C; r_slv[0] = '{1, 8'h81, 1'b0};
    r_addr[1] = 9'h1F0; r_wd[1] = 8'hC5; r_slv[1] = '{0, 8'h18, 1'b0};
    issue(2'b11, 1'b1);
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 2; i++) begin
        r_rw[i] = 1'($urandom);
        r_addr[i] = 9'($urandom);
        r_wd[i] = 8'($urandom);
        r_slv[i] = '{int'($urandom_range(0, 8)), 8'($urandom), $urandom_range(0, 4) == 0};
      end
      issue(2'($urandom_range(1, 3)), 1'b1);
    end
    repeat (5) @(negedge pclk);
    chk("sb_drain", sbq.size(), 0);
    chk("apb_drain", apbq.size(), 0);
    chk("slv_drain", slvq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
